// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bundle shared by the fetch unit and its memory.
// The fetch unit is the master: it issues req/addr and receives ack/data.
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, runs a single-outstanding req/ack fetch,
// presents each fetched word until the core retires it, and applies redirects.
// Misaligned fetch targets park in MISAL until a trap redirect moves the PC.
module instr_fetch #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    instr_fetch_if.master      im,
    output logic [31:0]        o_Instr,
    output logic [31:0]        o_PC,
    output logic               o_Stall,
    output logic               o_Fetch_misal,
    input  logic               i_Advance,
    input  logic               i_Redirect,
    input  logic [31:0]        i_Redirect_PC
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DISCARD = 3'd2,
        VALID   = 3'd3,
        MISAL   = 3'd4
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;

    // Next PC on retirement: redirect target wins over sequential PC+4 (wraps mod 2^32).
    logic [31:0] retire_pc;
    // In DISCARD the latest redirect overrides the pending PC.
    logic [31:0] discard_pc;

    // Retirement and discard target selection.
    always_comb begin
        retire_pc  = i_Redirect ? i_Redirect_PC : pc_reg + 32'd4;
        discard_pc = i_Redirect ? i_Redirect_PC : pc_reg;
    end

    // Fetch control FSM; all outputs are decoded from registered state only.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= IDLE;
            pc_reg    <= PC_RESET;
            instr_reg <= NOP_INSTR;
        end else begin
            case (state_reg)
                IDLE: state_reg <= FETCH;
                FETCH: begin
                    if (im.ack && i_Redirect) begin
                        // Returned word belongs to the old path; refetch at the target.
                        pc_reg    <= i_Redirect_PC;
                        state_reg <= (i_Redirect_PC[1:0] != 2'b00) ? MISAL : FETCH;
                    end else if (im.ack) begin
                        instr_reg <= im.data;
                        state_reg <= VALID;
                    end else if (i_Redirect) begin
                        pc_reg    <= i_Redirect_PC;
                        state_reg <= DISCARD;
                    end
                end
                DISCARD: begin
                    pc_reg <= discard_pc;
                    if (im.ack) begin
                        // A misaligned target reached while discarding must not be fetched.
                        state_reg <= (discard_pc[1:0] != 2'b00) ? MISAL : FETCH;
                    end
                end
                VALID: begin
                    if (i_Advance) begin
                        pc_reg    <= retire_pc;
                        state_reg <= (retire_pc[1:0] != 2'b00) ? MISAL : FETCH;
                    end
                end
                MISAL: begin
                    if (i_Advance && i_Redirect) begin
                        pc_reg    <= retire_pc;
                        state_reg <= (retire_pc[1:0] != 2'b00) ? MISAL : FETCH;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output decode: request only in FETCH, instruction valid in VALID/MISAL.
    always_comb begin
        im.req        = (state_reg == FETCH);
        im.addr       = pc_reg;
        o_PC          = pc_reg;
        o_Stall       = !((state_reg == VALID) || (state_reg == MISAL));
        o_Fetch_misal = (state_reg == MISAL);
        o_Instr       = (state_reg == VALID) ? instr_reg : NOP_INSTR;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: drives the memory side by hand and checks each step
// against hand-computed expectations.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [31:0] o_Instr;
    logic [31:0] o_PC;
    logic        o_Stall;
    logic        o_Fetch_misal;
    logic        i_Advance = 1'b0;
    logic        i_Redirect = 1'b0;
    logic [31:0] i_Redirect_PC = 32'd0;

    int checks_cnt = 0;
    int errors_cnt = 0;

    instr_fetch_if bus ();

    instr_fetch dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .im            (bus.master),
        .o_Instr       (o_Instr),
        .o_PC          (o_PC),
        .o_Stall       (o_Stall),
        .o_Fetch_misal (o_Fetch_misal),
        .i_Advance     (i_Advance),
        .i_Redirect    (i_Redirect),
        .i_Redirect_PC (i_Redirect_PC)
    );

    always #5 i_clk = ~i_clk;

    // Compare one observed value against its expectation and log the result.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Expect a pending request at exp_addr, answer it with zero wait, expect the word presented.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        check_val({tag, "_req"}, {31'd0, bus.req}, 32'd1);
        check_val({tag, "_addr"}, bus.addr, exp_addr);
        bus.ack  = 1'b1;
        bus.data = word;
        tick();
        bus.ack  = 1'b0;
        check_val({tag, "_stall"}, {31'd0, o_Stall}, 32'd0);
        check_val({tag, "_instr"}, o_Instr, word);
        check_val({tag, "_pc"}, o_PC, exp_addr);
    endtask

    // Retire the current instruction, optionally redirecting.
    task automatic retire(input logic redir, input logic [31:0] target);
        i_Advance     = 1'b1;
        i_Redirect    = redir;
        i_Redirect_PC = target;
        tick();
        i_Advance  = 1'b0;
        i_Redirect = 1'b0;
    endtask

    initial begin
        bus.ack  = 1'b0;
        bus.data = 32'd0;
        tick();
        tick();
        check_val("rst_req", {31'd0, bus.req}, 32'd0);
        check_val("rst_addr", bus.addr, 32'd0);
        check_val("rst_instr", o_Instr, NOP);
        check_val("rst_stall", {31'd0, o_Stall}, 32'd1);
        check_val("rst_misal", {31'd0, o_Fetch_misal}, 32'd0);

        // 1: first fetch after reset release
        i_rstn = 1'b1;
        tick();
        check_val("t1_stall_fetch", {31'd0, o_Stall}, 32'd1);
        serve("t1", 32'h0, 32'h0050_0093);
        check_val("t1_req_off", {31'd0, bus.req}, 32'd0);

        // 2: sequential fetch, stall toggles; advance while stalled is ignored
        retire(1'b0, 32'd0);
        check_val("t2_stall_on", {31'd0, o_Stall}, 32'd1);
        i_Advance = 1'b1;
        tick();
        i_Advance = 1'b0;
        check_val("t2_adv_stalled", bus.addr, 32'h4);
        serve("t2a", 32'h4, 32'h1111_0001);
        retire(1'b0, 32'd0);
        serve("t2b", 32'h8, 32'h1111_0002);
        retire(1'b0, 32'd0);
        serve("t2c", 32'hC, 32'h1111_0003);

        // stray ack and a lone redirect in VALID are ignored
        bus.ack = 1'b1;
        bus.data = 32'hBAD0_BAD0;
        i_Redirect = 1'b1;
        i_Redirect_PC = 32'h500;
        tick();
        bus.ack = 1'b0;
        i_Redirect = 1'b0;
        check_val("valid_hold_instr", o_Instr, 32'h1111_0003);
        check_val("valid_hold_pc", o_PC, 32'hC);

        // 3: advance+redirect
        retire(1'b1, 32'h40);
        serve("t3a", 32'h40, 32'h2222_0040);
        retire(1'b1, 32'h100);
        serve("t3b", 32'h100, 32'h2222_0100);

        // 4: redirect during FETCH with late ack
        retire(1'b0, 32'd0);
        check_val("t4_addr", bus.addr, 32'h104);
        i_Redirect = 1'b1;
        i_Redirect_PC = 32'h200;
        tick();
        i_Redirect = 1'b0;
        check_val("t4_disc_req", {31'd0, bus.req}, 32'd0);
        tick();
        tick();
        check_val("t4_disc_stall", {31'd0, o_Stall}, 32'd1);
        bus.ack = 1'b1;
        bus.data = 32'hDEAD_BEEF;
        tick();
        bus.ack = 1'b0;
        check_val("t4_late_stall", {31'd0, o_Stall}, 32'd1);
        check_val("t4_late_instr", o_Instr, NOP);
        serve("t4", 32'h200, 32'h3333_0200);

        // 5: misaligned target
        retire(1'b1, 32'h102);
        check_val("t5_misal", {31'd0, o_Fetch_misal}, 32'd1);
        check_val("t5_instr", o_Instr, NOP);
        check_val("t5_req", {31'd0, bus.req}, 32'd0);
        check_val("t5_stall", {31'd0, o_Stall}, 32'd0);
        check_val("t5_pc", o_PC, 32'h102);
        retire(1'b0, 32'd0);
        check_val("t5_hold_misal", {31'd0, o_Fetch_misal}, 32'd1);
        check_val("t5_hold_pc", o_PC, 32'h102);
        retire(1'b1, 32'h80);
        check_val("t5_clear_misal", {31'd0, o_Fetch_misal}, 32'd0);
        serve("t5", 32'h80, 32'h4444_0080);

        // PC wrap
        retire(1'b1, 32'hFFFF_FFFC);
        serve("wrapa", 32'hFFFF_FFFC, 32'h5555_FFFC);
        retire(1'b0, 32'd0);
        check_val("wrap_addr", bus.addr, 32'h0);
        check_val("wrap_req", {31'd0, bus.req}, 32'd1);

        // 6: async reset mid-FETCH, stray ack ignored
        i_rstn = 1'b0;
        #1;
        check_val("t6_req_async", {31'd0, bus.req}, 32'd0);
        bus.ack = 1'b1;
        bus.data = 32'hCAFE_CAFE;
        tick();
        i_rstn = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_val("t6_stall", {31'd0, o_Stall}, 32'd1);
        check_val("t6_instr", o_Instr, NOP);
        serve("t6", 32'h0, 32'h6666_0000);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
